// File: rtl/ddr2_cmd_arb_pkg.sv
// Shared definitions for the DDR2 command arbiter: command field layout,
// arbiter state type and burst-length decoding.
package ddr2_cmd_arb_pkg;

    localparam int unsigned CMD_W    = 34;
    localparam int unsigned DATA_W   = 128;
    localparam int unsigned OP_BIT   = 33;
    localparam int unsigned SIZE_MSB = 32;
    localparam int unsigned SIZE_LSB = 26;
    localparam int unsigned ADDR_MSB = 25;
    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned BEAT_W   = 8;

    // A size field of zero encodes the maximum burst.
    localparam logic [BEAT_W-1:0] SIZE0_BEATS = 8'd128;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WDATA
    } arb_state_e;

    function automatic logic [BEAT_W-1:0] burst_beats(input logic [CMD_W-1:0] cmd);
        logic [SIZE_MSB-SIZE_LSB:0] sz;
        sz = cmd[SIZE_MSB:SIZE_LSB];
        return (sz == '0) ? SIZE0_BEATS : {1'b0, sz};
    endfunction

endpackage

// File: rtl/ddr2_tag_fifo.sv
// Show-ahead FIFO of read-owner tags: records which requester each issued
// read belongs to so returning read data can be steered.
module ddr2_tag_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;

    // Extra pointer MSB distinguishes full from empty.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout_o  = empty_o ? 1'b0 : mem_q[rptr_q[AW-1:0]];

    // Pointer update; pops on empty and pushes on full are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

    // Tag storage; contents are only visible through the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/ddr2_cmd_arb.sv
// Two-requester round-robin arbiter in front of a DDR2 controller. Commands are
// latched, issued once the controller is ready, and write bursts are carried
// to completion before rearbitration.
module ddr2_cmd_arb
    import ddr2_cmd_arb_pkg::*;
#(
    parameter int unsigned TAG_DEPTH = 16
) (
    input  logic              ddr2_clk,
    input  logic              sys_rst,
    input  logic              um0_cmd_valid,
    input  logic [CMD_W-1:0]  um0_cmd,
    output logic              um0_cmd_ack,
    input  logic [DATA_W-1:0] um0_wdata,
    input  logic              um0_wvalid,
    output logic              um0_wack,
    input  logic              um1_cmd_valid,
    input  logic [CMD_W-1:0]  um1_cmd,
    output logic              um1_cmd_ack,
    input  logic [DATA_W-1:0] um1_wdata,
    input  logic              um1_wvalid,
    output logic              um1_wack,
    output logic              um2ddr_command_wrreq,
    output logic [CMD_W-1:0]  um2ddr_command,
    output logic              um2ddr_wrreq,
    output logic [DATA_W-1:0] um2ddr_data,
    input  logic              um2ddr_ready,
    input  logic              rd_owner_rdreq,
    output logic              rd_owner_id,
    output logic              rd_owner_empty
);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic              prio_q, prio_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;

    logic arb_g;
    logic issue;
    logic xfer;
    logic tag_push;
    logic tag_full;

    ddr2_tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i  (ddr2_clk),
        .rst_i  (sys_rst),
        .push_i (tag_push),
        .din_i  (grant_q),
        .pop_i  (rd_owner_rdreq),
        .dout_o (rd_owner_id),
        .full_o (tag_full),
        .empty_o(rd_owner_empty)
    );

    // State, grant, priority, latched command and beat counter registers.
    always_ff @(posedge ddr2_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            cmd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Arbitration, command issue and write-data steering.
    always_comb begin
        state_d              = state_q;
        grant_d              = grant_q;
        prio_d               = prio_q;
        cmd_d                = cmd_q;
        cnt_d                = cnt_q;
        arb_g                = 1'b0;
        issue                = 1'b0;
        xfer                 = 1'b0;
        tag_push             = 1'b0;
        um0_cmd_ack          = 1'b0;
        um1_cmd_ack          = 1'b0;
        um0_wack             = 1'b0;
        um1_wack             = 1'b0;
        um2ddr_command_wrreq = 1'b0;
        um2ddr_command       = '0;
        um2ddr_wrreq         = 1'b0;
        um2ddr_data          = '0;

        case (state_q)
            IDLE: begin
                if (um0_cmd_valid || um1_cmd_valid) begin
                    arb_g   = (um0_cmd_valid && um1_cmd_valid) ? prio_q : um1_cmd_valid;
                    grant_d = arb_g;
                    prio_d  = ~arb_g;
                    cmd_d   = arb_g ? um1_cmd : um0_cmd;
                    state_d = CMD;
                end
            end
            CMD: begin
                um2ddr_command = cmd_q;
                issue = um2ddr_ready && (cmd_q[OP_BIT] || !tag_full);
                if (issue) begin
                    um2ddr_command_wrreq = 1'b1;
                    um0_cmd_ack          = !grant_q;
                    um1_cmd_ack          = grant_q;
                    if (cmd_q[OP_BIT]) begin
                        cnt_d   = burst_beats(cmd_q);
                        state_d = WDATA;
                    end else begin
                        tag_push = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            WDATA: begin
                um2ddr_data  = grant_q ? um1_wdata : um0_wdata;
                xfer         = (grant_q ? um1_wvalid : um0_wvalid) && um2ddr_ready;
                um2ddr_wrreq = xfer;
                um0_wack     = xfer && !grant_q;
                um1_wack     = xfer && grant_q;
                if (xfer) begin
                    cnt_d = cnt_q - BEAT_W'(1);
                    if (cnt_q == BEAT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/ddr2_cmd_arb.md
DDR2_CMD_ARB -- requirements
Module: ddr2_cmd_arb

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 16, depth of the read-owner tag FIFO (power of 2).
REQ-002 SHALL have port ddr2_clk  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port sys_rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports umN_cmd_valid  in  1  requester N (N=0,1) has a command pending.
REQ-005 SHALL have ports umN_cmd  in  34  command: [33] op (1=write, 0=read), [32:26] size in 128-bit beats (0 means 128), [25:0] DDR2 address.
REQ-006 SHALL have ports umN_cmd_ack  out  1  one-cycle pulse, command accepted.
REQ-007 SHALL have ports umN_wdata  in  128, umN_wvalid  in  1, umN_wack  out  1  write-data beat handshake.
REQ-008 SHALL have ports um2ddr_command_wrreq  out  1, um2ddr_command  out  34, um2ddr_wrreq  out  1, um2ddr_data  out  128, um2ddr_ready  in  1  downstream DDR2 controller input side.
REQ-009 SHALL have ports rd_owner_rdreq  in  1, rd_owner_id  out  1, rd_owner_empty  out  1  read-return ownership queue (show-ahead).

Function
REQ-010 SHALL implement FSM states IDLE, CMD, WDATA.
REQ-011 IDLE: if any umN_cmd_valid, latch grant g and umg_cmd into registers, go CMD next cycle; no outputs asserted in IDLE.
REQ-012 Arbitration SHALL be round-robin: the requester not granted most recently has priority; after reset um0 has priority.
REQ-013 CMD: issue when um2ddr_ready=1 and (op=write or tag FIFO not full): um2ddr_command_wrreq=1 and umg_cmd_ack=1 for exactly that one cycle, um2ddr_command=latched command.
REQ-014 CMD, read issue: push g into tag FIFO same cycle, next state IDLE.
REQ-015 CMD, write issue: load beat counter with size (0 -> 128), next state WDATA.
REQ-016 CMD, issue condition false: remain in CMD, no pulses, latched command held.
REQ-017 WDATA: um2ddr_data=umg_wdata combinationally; um2ddr_wrreq=umg_wack=umg_wvalid AND um2ddr_ready; counter decrements per transferred beat.
REQ-018 WDATA: on the transfer of the last beat (counter=1) go IDLE; the other requester's wack SHALL stay 0 throughout.
REQ-019 Write burst SHALL NOT be interrupted by the other requester; rearbitration only from IDLE.
REQ-020 Minimum command-to-command spacing SHALL be 2 cycles (IDLE then CMD).
REQ-021 Tag FIFO: rd_owner_id=oldest entry, rd_owner_empty=1 when empty; rd_owner_rdreq while empty SHALL be ignored; simultaneous push and pop when full SHALL NOT occur because push is gated only on not-full before pop (pop-then-push same cycle permitted when not full).
REQ-022 umN_cmd_valid deasserted while latched in CMD SHALL NOT cancel the command (latched copy is issued).
REQ-023 um2ddr_data SHALL be 0 when not in WDATA.

Reset
REQ-024 On sys_rst: state=IDLE, priority=um0, counter=0, tag FIFO empty, all pulse outputs 0, um2ddr_command=0, rd_owner_empty=1, rd_owner_id=0.
REQ-025 Reset mid-burst SHALL abandon the burst; no further wack/wrreq after the reset cycle.

Structure
REQ-026 Shared package SHALL hold command field positions (OP_BIT=33, SIZE_MSB/LSB=32/26, ADDR_MSB/LSB=25/0), the state typedef and the 128-beat size-0 constant.
REQ-027 Tag FIFO SHALL be a sub-module ddr2_tag_fifo (sync, show-ahead, width 1, depth TAG_DEPTH, full/empty flags).

Verification
REQ-028 Single read: um0 read addr 0x100 size 4, ready=1 -> command_wrreq pulses at cycle 2, um0_cmd_ack same cycle, rd_owner_id=0, empty=0 next cycle.
REQ-029 Contention: both valid continuously with reads -> issue order um0, um1, um0, um1; tag FIFO contents 0,1,0,1.
REQ-030 Write burst size 3 with um2ddr_ready low on 2nd beat -> exactly 3 wrreq pulses with data beats in order, return to IDLE after 3rd; um1 request waits.
REQ-031 Size field 0 write -> exactly 128 data beats transferred before next command.
REQ-032 Tag full: 16 reads with no rd_owner_rdreq, 17th read stalls in CMD; one rd_owner_rdreq -> 17th issues next cycle.
REQ-033 sys_rst asserted at beat 2 of 8-beat write -> wack/wrreq 0 from next cycle, state IDLE, rd_owner_empty=1.
